// File: rtl/nand_share_arb.sv
// Round-robin arbiter sharing one registered NAND unit among NREQ requesters.
// Grants one requester, runs LAT cycles of EXEC, returns a tagged result.
module nand_share_arb #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] a,
    input  logic [NREQ-1:0] b,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            rsp_valid,
    output logic            rsp_y,
    output logic [IDW-1:0]  rsp_id,
    input  logic            rsp_ready
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            a_q, a_d;
    logic            b_q, b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_y_q, rsp_y_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  idx;

    // Search upward from ptr, wrapping, for the first active request.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr_q) + i) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        gnt         = '0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt[win] = 1'b1;
                    a_d      = a[win];
                    b_d      = b[win];
                    id_d     = win;
                    ptr_d    = IDW'((int'(win) + 1) % NREQ);
                    cnt_d    = 4'(LAT - 1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_y_d     = ~(a_q & b_q);
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Grant must never leak out while reset is asserted.
        if (!rst_n) begin
            gnt = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= 1'b0;
            rsp_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_nand_share_arb.sv
// Directed bench for nand_share_arb with a result scoreboard.
module tb_nand_share_arb;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] gnt;
    logic       busy;
    logic       rsp_valid;
    logic       rsp_y;
    logic [1:0] rsp_id;
    logic       rsp_ready;

    int n_assert;
    int n_fail;
    int cyc_n;
    int sb[$];
    int gids[$];
    int gcyc[$];

    nand_share_arb #(.NREQ(4), .LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a         (a),
        .b         (b),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Settle combinational outputs, then update the scoreboard.
    task automatic look();
        int w;
        int e;
        #1;
        if (rst_n && gnt != 4'b0) begin
            w = 0;
            for (int i = 0; i < 4; i++)
                if (gnt[i]) w = i;
            sb.push_back((w << 1) | int'(~(a[w] & b[w]) & 1'b1));
        end
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_rsp_y", 32'(rsp_y), 32'(e & 1));
                chk("sb_rsp_id", 32'(rsp_id), 32'(e >> 1));
            end
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        req = 4'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            look();
            if (!busy) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    task automatic issue(input int w, input bit av, input bit bv);
        bit got;
        got = 1'b0;
        req = 4'b0;
        req[w] = 1'b1;
        a[w] = av;
        b[w] = bv;
        look();
        chk("issue_gnt", 32'(gnt), 32'(req));
        cycle();
        req = 4'b0;
        for (int k = 0; k < 20; k++) begin
            look();
            if (rsp_valid) begin
                chk("tt_rsp_y", 32'(rsp_y), 32'(!(av && bv)));
                chk("tt_rsp_id", 32'(rsp_id), 32'(w));
                got = 1'b1;
                cycle();
                break;
            end
            cycle();
        end
        chk("issue_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        bit ok;
        n_assert  = 0;
        n_fail    = 0;
        cyc_n     = 0;
        rst_n     = 1'b0;
        req       = 4'b1111;
        a         = 4'b0;
        b         = 4'b0;
        rsp_ready = 1'b1;
        cycle();

        // Reset held for two cycles with all requests active.
        for (int k = 0; k < 2; k++) begin
            look();
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            cycle();
        end
        rst_n = 1'b1;
        look();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        cycle();
        drain();

        // Single request from requester 2 with a=b=1.
        req = 4'b0100;
        a   = 4'b0100;
        b   = 4'b0100;
        look();
        chk("single_gnt_T", 32'(gnt), 32'h4);
        cycle();
        req = 4'b0;
        look();
        chk("single_gnt_T1", 32'(gnt), 32'h0);
        chk("single_valid_T1", 32'(rsp_valid), 32'h0);
        cycle();
        look();
        chk("single_valid_T2", 32'(rsp_valid), 32'h0);
        cycle();
        look();
        chk("single_valid_T3", 32'(rsp_valid), 32'h1);
        chk("single_y_T3", 32'(rsp_y), 32'h0);
        chk("single_id_T3", 32'(rsp_id), 32'h2);
        cycle();
        look();
        chk("single_idle_T4", 32'(busy), 32'h0);

        // Truth table through requester 1.
        issue(1, 1'b0, 1'b0);
        issue(1, 1'b0, 1'b1);
        issue(1, 1'b1, 1'b0);
        issue(1, 1'b1, 1'b1);
        drain();

        // Reset so the pointer restarts at 0 for the round-robin run.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;

        req = 4'b1111;
        a   = 4'b1010;
        b   = 4'b1100;
        for (int k = 0; k < 40; k++) begin
            look();
            if (gnt != 4'b0) begin
                for (int i = 0; i < 4; i++)
                    if (gnt[i]) gids.push_back(i);
                gcyc.push_back(cyc_n);
            end
            cycle();
            if (gids.size() == 6) break;
        end
        req = 4'b0;
        chk("rr_count", 32'(gids.size()), 32'd6);
        if (gids.size() == 6) begin
            for (int i = 0; i < 6; i++)
                chk("rr_order", 32'(gids[i]), 32'(i % 4));
            for (int i = 1; i < 6; i++)
                chk("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd4);
        end
        drain();

        // Backpressure in RESP for five cycles.
        req = 4'b0001;
        a   = 4'b0001;
        b   = 4'b0001;
        look();
        chk("bp_gnt", 32'(gnt), 32'h1);
        cycle();
        req = 4'b0;
        rsp_ready = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            look();
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        chk("bp_wait_timeout", 32'(ok), 32'd1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            look();
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_y", 32'(rsp_y), 32'h0);
            chk("bp_id", 32'(rsp_id), 32'h0);
            chk("bp_gnt0", 32'(gnt), 32'h0);
            chk("bp_busy", 32'(busy), 32'h1);
            cycle();
        end
        rsp_ready = 1'b1;
        look();
        cycle();
        look();
        chk("bp_next_gnt", 32'(gnt), 32'h2);
        cycle();
        drain();

        // Reset during EXEC discards the operation and clears ptr.
        req = 4'b0100;
        a   = 4'b0100;
        b   = 4'b0000;
        look();
        chk("mid_gnt", 32'(gnt), 32'h4);
        cycle();
        req = 4'b0;
        rst_n = 1'b0;
        look();
        cycle();
        rst_n = 1'b1;
        sb.delete();
        look();
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_valid", 32'(rsp_valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            look();
            chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
        end
        req = 4'b1010;
        look();
        chk("mid_next_gnt", 32'(gnt), 32'h2);
        cycle();
        drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
